// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit ASIP pipeline (EXE/MEM -> MEM/WB).
// Define MEM_TIMEOUT_EN to abort stuck data-memory accesses after TIMEOUT_CYCLES.
module mem_stage #(
   parameter int unsigned ARQ            = 16,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid_in,
   input  logic           wb_enable_in,
   input  logic           mem_enable_in,
   input  logic [ARQ-1:0] src1_in,
   input  logic [ARQ-1:0] srcdest_in,
   input  logic [ARQ-1:0] alu_result_in,
   output logic           stall_out,
   output logic           dmem_req,
   output logic           dmem_we,
   output logic [ARQ-1:0] dmem_addr,
   output logic [ARQ-1:0] dmem_wdata,
   input  logic [ARQ-1:0] dmem_rdata,
   input  logic           dmem_ack,
   output logic           valid_out,
   output logic           wb_enable_out,
   output logic [ARQ-1:0] dest_out,
   output logic [ARQ-1:0] result_out,
   output logic           mem_error
);

   typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   state_t         state, state_nx;
   logic           start, done;
   logic           lat_wb;
   logic [ARQ-1:0] lat_dest;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;
   logic          abort;

   assign tmo_hit = (state == ACCESS) && (tmo_cnt == CW'(TIMEOUT_CYCLES));
   // Stall also drops on the abort cycle so upstream does not re-present the squashed op.
   assign stall_out = (state == ACCESS) && !dmem_ack && !tmo_hit;
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign stall_out          = (state == ACCESS) && !dmem_ack;
   assign mem_error          = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      start    = 1'b0;
      done     = 1'b0;
`ifdef MEM_TIMEOUT_EN
      abort    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (valid_in && mem_enable_in) begin
               start    = 1'b1;
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            if (dmem_ack) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo_hit) begin
               abort    = 1'b1;
               state_nx = IDLE;
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   // The request registers double as the latched op: dmem_we marks a store and
   // dmem_addr is the store's completion result.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out     <= 1'b0;
         wb_enable_out <= 1'b0;
         dest_out      <= '0;
         result_out    <= '0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         lat_wb        <= 1'b0;
         lat_dest      <= '0;
      end else begin
         valid_out <= 1'b0;
         if (state == IDLE && valid_in && !mem_enable_in) begin
            valid_out     <= 1'b1;
            wb_enable_out <= wb_enable_in;
            dest_out      <= src1_in;
            result_out    <= alu_result_in;
         end
         if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= !wb_enable_in;
            dmem_addr  <= alu_result_in;
            dmem_wdata <= srcdest_in;
            lat_wb     <= wb_enable_in;
            lat_dest   <= src1_in;
         end
         if (done) begin
            dmem_req      <= 1'b0;
            valid_out     <= 1'b1;
            wb_enable_out <= lat_wb;
            dest_out      <= lat_dest;
            result_out    <= dmem_we ? dmem_addr : dmem_rdata;
         end
`ifdef MEM_TIMEOUT_EN
         if (abort) begin
            dmem_req      <= 1'b0;
            valid_out     <= 1'b1;
            wb_enable_out <= 1'b0;
            dest_out      <= lat_dest;
            result_out    <= '0;
         end
`endif
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt   <= '0;
         mem_error <= 1'b0;
      end else begin
         if (start)
            tmo_cnt <= '0;
         else if (state == ACCESS && !dmem_ack && !tmo_hit)
            tmo_cnt <= tmo_cnt + CW'(1);
         if (abort)
            mem_error <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a reference memory and a
// randomised data-memory responder; the timeout section runs only with MEM_TIMEOUT_EN.
module tb_mem_stage;
   localparam int unsigned W   = 16;
   localparam int unsigned TMO = 15;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_in, wb_enable_in, mem_enable_in;
   logic [W-1:0] src1_in, srcdest_in, alu_result_in;
   logic         stall_out, dmem_req, dmem_we, dmem_ack;
   logic [W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic         valid_out, wb_enable_out, mem_error;
   logic [W-1:0] dest_out, result_out;

   always #5 clk = ~clk;

   mem_stage #(.ARQ(W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .wb_enable_in(wb_enable_in),
      .mem_enable_in(mem_enable_in), .src1_in(src1_in), .srcdest_in(srcdest_in),
      .alu_result_in(alu_result_in), .stall_out(stall_out), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .valid_out(valid_out),
      .wb_enable_out(wb_enable_out), .dest_out(dest_out), .result_out(result_out),
      .mem_error(mem_error)
   );

   typedef struct {
      logic         wb;
      logic [W-1:0] dest;
      logic [W-1:0] res;
      bit           chk_dest;
   } exp_t;

   typedef struct {
      bit           v, wb, mem;
      logic [W-1:0] s1, sd, alu;
      int unsigned  dly;
   } ins_t;

   exp_t sb[$];
   int   done_q[$];
   ins_t prog[$];

   int checks = 0, errors = 0;
   int cyc = 0;
   bit started = 1'b0;
   int merr_cyc = -1;

   bit           pend_active = 1'b0;
   bit           pend_we;
   logic [W-1:0] pend_addr, pend_wdata;
   int unsigned  pend_dly, wait_cnt;

   logic [W-1:0] ref_mem [32];
   logic [W-1:0] dmem_arr[32];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic ins_t mk(bit v, bit wb, bit mem, logic [W-1:0] s1, logic [W-1:0] sd,
                               logic [W-1:0] alu, int unsigned dly);
      ins_t i;
      i.v = v; i.wb = wb; i.mem = mem; i.s1 = s1; i.sd = sd; i.alu = alu; i.dly = dly;
      return i;
   endfunction

   function automatic ins_t rand_ins();
      return mk($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
   endfunction

   // One clock of upstream + memory responder, driven just after the rising edge.
   task automatic cycle();
      bit   acc_now;
      bit   tmo_now;
      ins_t cur;
      exp_t e;
      @(posedge clk);
      #1;
      acc_now    = pend_active;
      tmo_now    = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 16'($urandom);
      if (acc_now) begin
         check("dmem_req_access", 32'(dmem_req), 32'd1);
         check("dmem_we", 32'(dmem_we), 32'(pend_we));
         check("dmem_addr", 32'(dmem_addr), 32'(pend_addr));
         check("dmem_wdata", 32'(dmem_wdata), 32'(pend_wdata));
         if (wait_cnt == pend_dly) begin
            dmem_ack = 1'b1;
            if (pend_we) dmem_arr[pend_addr[4:0]] = pend_wdata;
            else         dmem_rdata = dmem_arr[pend_addr[4:0]];
            pend_active = 1'b0;
            done_q.push_back(cyc + 1);
         end
`ifdef MEM_TIMEOUT_EN
         else if (wait_cnt == TMO) begin
            tmo_now     = 1'b1;
            pend_active = 1'b0;
            done_q.push_back(cyc + 1);
            e = sb.pop_back();
            e.wb = 1'b0; e.res = '0; e.chk_dest = 1'b0;
            sb.push_back(e);
            merr_cyc = cyc + 1;
         end
`endif
         else begin
            wait_cnt++;
         end
      end else begin
         check("dmem_req_idle", 32'(dmem_req), 32'd0);
         dmem_ack = ($urandom_range(0, 3) == 0);
      end

      if (prog.size() > 0) cur = prog[0];
      else cur = mk(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom), 16'($urandom), 0);
      valid_in      = cur.v;
      wb_enable_in  = cur.wb;
      mem_enable_in = cur.mem;
      src1_in       = cur.s1;
      srcdest_in    = cur.sd;
      alu_result_in = cur.alu;

      if (!acc_now) begin
         if (cur.v) begin
            if (!cur.mem) begin
               e = '{cur.wb, cur.s1, cur.alu, 1'b1};
               done_q.push_back(cyc + 1);
            end else begin
               if (cur.wb) e = '{1'b1, cur.s1, ref_mem[cur.alu[4:0]], 1'b1};
               else begin
                  e = '{1'b0, cur.s1, cur.alu, 1'b1};
                  ref_mem[cur.alu[4:0]] = cur.sd;
               end
               pend_active = 1'b1;
               pend_we     = !cur.wb;
               pend_addr   = cur.alu;
               pend_wdata  = cur.sd;
               pend_dly    = cur.dly;
               wait_cnt    = 0;
            end
            sb.push_back(e);
         end
         if (prog.size() > 0) void'(prog.pop_front());
      end
      #1;
      check("stall_out", 32'(stall_out), 32'(acc_now && !dmem_ack && !tmo_now));
   endtask

   task automatic run_drain(input int unsigned budget);
      int unsigned n = 0;
      while ((prog.size() > 0 || pend_active) && n < budget) begin
         cycle();
         n++;
      end
      check("drain_prog", 32'(prog.size()), 32'd0);
      check("drain_pend", 32'(pend_active), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
      check({tag, "_wb_enable_out"}, 32'(wb_enable_out), 32'd0);
      check({tag, "_dest_out"}, 32'(dest_out), 32'd0);
      check({tag, "_result_out"}, 32'(result_out), 32'd0);
      check({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
      check({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
      check({tag, "_dmem_addr"}, 32'(dmem_addr), 32'd0);
      check({tag, "_dmem_wdata"}, 32'(dmem_wdata), 32'd0);
      check({tag, "_stall_out"}, 32'(stall_out), 32'd0);
      check({tag, "_mem_error"}, 32'(mem_error), 32'd0);
   endtask

   task automatic do_reset(input bit drop_inflight);
      rst      = 1'b1;
      valid_in = 1'b0;
      dmem_ack = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (drop_inflight && pend_active) void'(sb.pop_back());
      pend_active = 1'b0;
      merr_cyc    = -1;
      check_zero("rst");
      dmem_ack   = 1'b1;
      dmem_rdata = 16'hDEAD;
   endtask

   always @(negedge clk) begin
      bit   exp_v;
      exp_t e;
      if (started) begin
         exp_v = (done_q.size() > 0) && (done_q[0] == cyc);
         check("valid_out", 32'(valid_out), 32'(exp_v));
         if (done_q.size() > 0 && done_q[0] <= cyc) void'(done_q.pop_front());
         if (valid_out) begin
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
            else begin
               e = sb.pop_front();
               check("wb_enable_out", 32'(wb_enable_out), 32'(e.wb));
               check("result_out", 32'(result_out), 32'(e.res));
               if (e.chk_dest) check("dest_out", 32'(dest_out), 32'(e.dest));
            end
         end
         check("mem_error", 32'(mem_error), 32'(merr_cyc >= 0 && cyc >= merr_cyc));
         if (cyc > 50000) begin
            $display("FAIL watchdog: got cycle %0d, expected completion before 50000", cyc);
            $fatal(1, "watchdog expired");
         end
      end
   end

   initial begin
      rst = 1'b1; valid_in = 1'b0; wb_enable_in = 1'b0; mem_enable_in = 1'b0;
      src1_in = '0; srcdest_in = '0; alu_result_in = '0; dmem_ack = 1'b0; dmem_rdata = '0;
      for (int i = 0; i < 32; i++) begin
         ref_mem[i]  = 16'($urandom);
         dmem_arr[i] = ref_mem[i];
      end
      ref_mem[16]  = 16'hBEEF;
      dmem_arr[16] = 16'hBEEF;
      repeat (2) @(posedge clk);
      #1;
      check_zero("init");
      rst     = 1'b0;
      started = 1'b1;

      prog.push_back(mk(1, 1, 0, 16'd1821, 16'h0000, 16'd1421, 0));   // ALU op
      prog.push_back(mk(1, 0, 1, 16'h0007, 16'd1114, 16'h0040, 2));   // store, ack in 3rd ACCESS cycle
      prog.push_back(mk(1, 1, 1, 16'h0005, 16'h0000, 16'h0010, 0));   // load, immediate ack
      prog.push_back(mk(1, 1, 1, 16'h000C, 16'h0000, 16'h0022, 3));   // load ...
      prog.push_back(mk(1, 0, 0, 16'h0ABC, 16'h0000, 16'h0DEF, 0));   // ... then held ALU op
      prog.push_back(mk(0, 1, 1, 16'h1111, 16'h2222, 16'h3333, 0));   // bubble
      prog.push_back(mk(1, 0, 1, 16'h0001, 16'hA5A5, 16'hFFFF, 0));   // back-to-back stores
      prog.push_back(mk(1, 0, 1, 16'h0002, 16'h5A5A, 16'h0000, 1));
      run_drain(100);

      prog.push_back(mk(1, 1, 1, 16'h0004, 16'h0000, 16'h0033, 255));
      for (int n = 0; n < 10 && !pend_active; n++) cycle();
      check("rst_test_entered", 32'(pend_active), 32'd1);
      cycle();
      cycle();
      do_reset(1'b1);

      for (int n = 0; n < 300; n++) prog.push_back(rand_ins());
      run_drain(5000);

`ifdef MEM_TIMEOUT_EN
      prog.push_back(mk(1, 0, 1, 16'h0042, 16'h5A5A, 16'h0077, 255));
      prog.push_back(mk(1, 1, 0, 16'h0009, 16'h0000, 16'h1234, 0));
      run_drain(60);
      repeat (3) cycle();
      do_reset(1'b0);
`endif

      repeat (4) cycle();
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("done_q_empty", 32'(done_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
